// File: rtl/mimo_symbol_encoder_pkg.sv
// Shared definitions for the MIMO symbol encoder.
//   - default geometry (M layers, WL-bit signed words)
//   - 2-bit 4-PAM symbol codes: 00->-3, 01->-1, 10->+1, 11->+3
//   - FSM state encoding
//   - saturation helper used to clamp the wide row sum back to WL bits
package mimo_symbol_encoder_pkg;

  localparam int M_DEFAULT  = 4;
  localparam int WL_DEFAULT = 15;

  localparam logic [1:0] SYM_M3 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b10;
  localparam logic [1:0] SYM_P3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Clamp a sign-extended value into the signed range of a wl-bit word.
  // The caller truncates the result to wl bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int wl);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (wl - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wl - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mimo_symbol_encoder_pam4_scale.sv
// pam4_scale: multiplies one signed R word by a 4-PAM symbol (+-1 / +-3)
// using only shift, add and negate.
// Ports:
//   code  in  2       symbol code (see package)
//   r     in  WL      signed R entry
//   p     out WL+2    signed product R*s (wide enough for -3 * min(R))
module pam4_scale
  import mimo_symbol_encoder_pkg::*;
#(
  parameter int WL = WL_DEFAULT
) (
  input  logic        [1:0]  code,
  input  logic signed [WL-1:0] r,
  output logic signed [WL+1:0] p
);

  logic signed [WL+1:0] r_ext;
  logic signed [WL+1:0] r_x3;

  assign r_ext = {{2{r[WL-1]}}, r};
  assign r_x3  = (r_ext <<< 1) + r_ext;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    p = '0;
    unique case (code)
      SYM_M3: p = -r_x3;
      SYM_M1: p = -r_ext;
      SYM_P1: p = r_ext;
      SYM_P3: p = r_x3;
      default: p = '0;
    endcase
  end

endmodule

// File: rtl/mimo_symbol_encoder.sv
// mimo_symbol_encoder: maps a vector of M 4-PAM symbols through an
// upper-triangular R matrix and streams the rows bottom-up (layer M-1 first,
// layer 0 last) as noiseless received samples for a detector stage.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input handshake; in_ready is high only when idle
//   in_bits         2-bit code per layer, layer j at [2j+1:2j]
//   in_r            R entry (i,j) at word i*M+j; entries below diagonal ignored
//   out_valid/ready row output handshake
//   out_y           saturated sum_{j>=i} R(i,j)*s(j) for row i
//   out_rarr        row i entries at word j (j>=i), zero for j<i
//   out_layer       row index i, out_last high for row 0
//   out_bits        copy of the accepted in_bits, held for the whole vector
// Optional feature: define MIMO_ENC_NOISE_EN to add small LFSR noise (-4..+3)
// to each row sum before saturation.
module mimo_symbol_encoder
  import mimo_symbol_encoder_pkg::*;
#(
  parameter  int M  = M_DEFAULT,
  parameter  int WL = WL_DEFAULT,
  localparam int LW = (M > 1) ? $clog2(M) : 1,
  localparam int SW = WL + 2 + $clog2(M)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*M-1:0]        in_bits,
  input  logic [M*M*WL-1:0]     in_r,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [WL-1:0]  out_y,
  output logic [M*WL-1:0]       out_rarr,
  output logic [LW-1:0]         out_layer,
  output logic                  out_last,
  output logic [2*M-1:0]        out_bits
);

  state_t              state;
  state_t              state_n;
  logic [LW-1:0]       row;
  logic [2*M-1:0]      bits_q;
  logic [M*M*WL-1:0]   r_q;
  logic                capture;
  logic [M*WL-1:0]     row_words;
  logic signed [WL+1:0] term [M];
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] sum_n;
  logic signed [WL-1:0] y_n;
  logic [M*WL-1:0]     rarr_n;

  assign capture   = (state == ST_IDLE) && in_valid;
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_EMIT);
  assign out_bits  = bits_q;

  // The whole R row for the current layer; lower-triangle words are masked below.
  assign row_words = r_q[int'(row)*M*WL +: M*WL];

  for (genvar j = 0; j < M; j++) begin : g_scale
    pam4_scale #(.WL(WL)) u_scale (
      .code (bits_q[2*j +: 2]),
      .r    (row_words[j*WL +: WL]),
      .p    (term[j])
    );
  end

  always_comb begin
    sum    = '0;
    rarr_n = '0;
    for (int j = 0; j < M; j++) begin
      if (j >= int'(row)) begin
        sum = sum + SW'(term[j]);
        rarr_n[j*WL +: WL] = row_words[j*WL +: WL];
      end
    end
  end

`ifdef MIMO_ENC_NOISE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (state == ST_CALC) begin
      // Fibonacci form, taps 16,14,13,11.
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign sum_n = sum + SW'($signed(lfsr[2:0]));
`else
  assign sum_n = sum;
`endif

  assign y_n = WL'(sat_signed(64'(sum_n), WL));

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (in_valid)  state_n = ST_CALC;
      ST_CALC:                state_n = ST_EMIT;
      ST_EMIT: if (out_ready) state_n = (row == '0) ? ST_IDLE : ST_CALC;
      default:                state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state     <= ST_IDLE;
      row       <= '0;
      bits_q    <= '0;
      out_y     <= '0;
      out_rarr  <= '0;
      out_layer <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_n;
      if (capture) begin
        bits_q <= in_bits;
        row    <= LW'(M - 1);
      end
      if (state == ST_CALC) begin
        out_y     <= y_n;
        out_rarr  <= rarr_n;
        out_layer <= row;
        out_last  <= (row == '0);
      end
      if ((state == ST_EMIT) && out_ready && (row != '0)) begin
        row <= row - LW'(1);
      end
    end
  end

  // NOTE: the R capture register has no reset; it is only read after a
  // capture has loaded it, and the FSM reset alone discards an in-flight vector.
  always_ff @(posedge clk) begin
    if (capture) begin
      r_q <= in_r;
    end
  end

endmodule

// File: tb/tb_mimo_symbol_encoder.sv
// Directed self-checking bench for mimo_symbol_encoder (default build, M=4, WL=15).
module tb_mimo_symbol_encoder;

  localparam int M  = 4;
  localparam int WL = 15;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [2*M-1:0]       in_bits;
  logic [M*M*WL-1:0]    in_r;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WL-1:0] out_y;
  logic [M*WL-1:0]      out_rarr;
  logic [1:0]           out_layer;
  logic                 out_last;
  logic [2*M-1:0]       out_bits;

  int total = 0;
  int bad   = 0;

  mimo_symbol_encoder #(.M(M), .WL(WL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .in_r      (in_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_rarr  (out_rarr),
    .out_layer (out_layer),
    .out_last  (out_last),
    .out_bits  (out_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M*WL-1:0] row4(input int w0, input int w1, input int w2, input int w3);
    logic [M*WL-1:0] v;
    v = {15'(w3), 15'(w2), 15'(w1), 15'(w0)};
    return v;
  endfunction

  // Diagonal d, zeros above, junk below the diagonal.
  function automatic logic [M*M*WL-1:0] r_diag(input int d);
    logic [M*M*WL-1:0] v;
    v = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        v[(i*M+j)*WL +: WL] = (j == i) ? 15'(d) : ((j < i) ? 15'(777) : 15'(0));
    return v;
  endfunction

  // All upper-triangle entries u, junk below the diagonal.
  function automatic logic [M*M*WL-1:0] r_upper(input int u);
    logic [M*M*WL-1:0] v;
    v = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        v[(i*M+j)*WL +: WL] = (j >= i) ? 15'(u) : 15'(777);
    return v;
  endfunction

  function automatic logic [M*M*WL-1:0] r_mixed();
    logic [M*M*WL-1:0] v;
    v = {row4(1000, 1000, 1000, -8),
         row4(1000, 1000, 9, -2),
         row4(1000, 4, -3, 6),
         row4(5, -7, 2, 1)};
    return v;
  endfunction

  // Called right after a posedge; returns #1 after the accepting edge.
  task automatic apply_vector(input logic [2*M-1:0] b, input logic [M*M*WL-1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", in_ready, 1);
    in_bits  = b;
    in_r     = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for a row, checks it and the cycle gap, consumes it.
  task automatic expect_row(input logic [1:0] layer, input int y, input logic last);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    check("row_valid", out_valid, 1);
    check("row_gap", n, 2);
    check("row_in_ready", in_ready, 0);
    check("row_layer", out_layer, layer);
    check("row_y", out_y, y);
    check("row_last", out_last, last);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_bits   = '0;
    in_r      = '0;

    // Reset state.
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_layer", out_layer, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_bits", out_bits, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Diagonal 64, all +3: every row 192, rows bottom-up, last only on row 0.
    apply_vector(8'hFF, r_diag(64));
    expect_row(2'd3, 192, 1'b0);
    check("diag_rarr3", out_rarr, row4(0, 0, 0, 64));
    check("diag_bits", out_bits, 8'hFF);
    expect_row(2'd2, 192, 1'b0);
    expect_row(2'd1, 192, 1'b0);
    check("diag_rarr1", out_rarr, row4(0, 64, 0, 0));
    expect_row(2'd0, 192, 1'b1);
    @(negedge clk);
    check("diag_idle", in_ready, 1);
    check("diag_no_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Upper 100, all +3: 300, 600, 900, 1200.
    apply_vector(8'hFF, r_upper(100));
    expect_row(2'd3, 300, 1'b0);
    check("up_rarr3", out_rarr, row4(0, 0, 0, 100));
    expect_row(2'd2, 600, 1'b0);
    expect_row(2'd1, 900, 1'b0);
    check("up_rarr1", out_rarr, row4(0, 100, 100, 100));
    expect_row(2'd0, 1200, 1'b1);

    // Saturation both ways.
    apply_vector(8'hFF, r_upper(16383));
    expect_row(2'd3, 16383, 1'b0);
    expect_row(2'd2, 16383, 1'b0);
    expect_row(2'd1, 16383, 1'b0);
    expect_row(2'd0, 16383, 1'b1);
    apply_vector(8'h00, r_upper(16383));
    expect_row(2'd3, -16384, 1'b0);
    expect_row(2'd2, -16384, 1'b0);
    expect_row(2'd1, -16384, 1'b0);
    expect_row(2'd0, -16384, 1'b1);

    // Mixed symbols s=[-3,-1,+1,+3], signed R, with a 5-cycle stall on row 2
    // during which in_valid pulses must be ignored.
    apply_vector(8'hE4, r_mixed());
    expect_row(2'd3, -24, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_layer", out_layer, 2);
      check("stall_y", out_y, 3);
      in_valid = 1'b1;
      in_bits  = 8'h00;
    end
    @(negedge clk);
    check("stall_end_y", out_y, 3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_row(2'd1, 11, 1'b0);
    check("mix_rarr1", out_rarr, row4(0, 4, -3, 6));
    check("mix_bits", out_bits, 8'hE4);
    expect_row(2'd0, -3, 1'b1);
    check("mix_rarr0", out_rarr, row4(5, -7, 2, 1));
    @(negedge clk);
    check("mix_not_reaccepted", out_valid, 0);
    @(negedge clk);
    check("mix_still_idle", out_valid, 0);
    check("mix_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Reset during layer 2 EMIT, then a fresh vector.
    apply_vector(8'hFF, r_diag(64));
    expect_row(2'd3, 192, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_layer", out_layer, 2);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_y", out_y, 0);
    check("mid_rst_layer", out_layer, 0);
    check("mid_rst_rarr", out_rarr, 0);
    check("mid_rst_bits", out_bits, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    apply_vector(8'hFF, r_upper(100));
    expect_row(2'd3, 300, 1'b0);
    expect_row(2'd2, 600, 1'b0);
    expect_row(2'd1, 900, 1'b0);
    expect_row(2'd0, 1200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
